// File: rtl/reg_port_arbiter.sv
// Round-robin arbiter sharing one ram-like register port between NUM_REQ requesters.
// Latency: accept edge -> 1-cycle ACCESS strobe -> response from the following cycle (3 cycles/txn min).
// Backpressure: one transaction in flight; req_ready_o only in IDLE, RESP holds until rsp_ready_i[idx_q].
module reg_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  input  logic [NUM_REQ-1:0]            rsp_ready_i,
  output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
  output logic [ADDR_WIDTH-1:0]         address_o,
  output logic                          en_o,
  output logic                          we_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  input  logic [DATA_WIDTH-1:0]         data_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   we_q, we_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

  logic                   win_vld;
  logic [IDX_W-1:0]       win_idx;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic                   win_we;
  logic [DATA_WIDTH-1:0]  win_wdata;

  // (base + offset) modulo NUM_REQ; with NUM_REQ=1 this is always 0, so ptr_q never moves.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offset);
    int sum;
    sum = (int'(base) + offset) % NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // Pick the first valid requester at or after ptr_q (wrapping) and mux out its payload.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_vld && req_valid_i[wrap_idx(ptr_q, i)]) begin
        win_vld = 1'b1;
        win_idx = wrap_idx(ptr_q, i);
      end
    end
    win_addr  = req_addr_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    win_we    = req_we_i[win_idx];
    win_wdata = req_wdata_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Next-state and output decode; every output sits at zero unless its state drives it.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    address_o   = '0;
    en_o        = 1'b0;
    we_o        = 1'b0;
    data_o      = '0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          // A grant shown during reset would be dropped by the reset edge, so hide it.
          req_ready_o[win_idx] = !rst_i;
          state_d = ACCESS;
          ptr_d   = wrap_idx(win_idx, 1);
          idx_d   = win_idx;
          addr_d  = win_addr;
          we_d    = win_we;
          wdata_d = win_wdata;
        end
      end
      ACCESS: begin
        en_o      = 1'b1;
        address_o = addr_q;
        we_o      = we_q;
        data_o    = wdata_q;
        // Register file read data is combinational from address_o, so it is valid now.
        rdata_d   = we_q ? '0 : data_i;
        state_d   = RESP;
      end
      RESP: begin
        rsp_valid_o[idx_q] = 1'b1;
        rsp_rdata_o        = rdata_q;
        if (rsp_ready_i[idx_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Testbench for reg_port_arbiter: two-requester instance driven from a vector table with a
// scoreboard queue, plus hand sequences for backpressure, mid-response reset and a
// three-requester instance for pointer wrap.
module tb_reg_port_arbiter;

  logic         clk;
  logic         rst_i;

  // Two-requester instance
  logic [1:0]   req_valid_i, req_ready_o, req_we_i, rsp_valid_o, rsp_ready_i;
  logic [127:0] req_addr_i, req_wdata_i;
  logic [63:0]  rsp_rdata_o, address_o, data_o, data_i;
  logic         en_o, we_o;

  // Three-requester instance
  logic [2:0]   b_valid, b_ready, b_we, b_rsp_valid, b_rsp_ready;
  logic [191:0] b_addr, b_wdata;
  logic [63:0]  b_rdata, b_address, b_data, b_data_i;
  logic         b_en, b_wen;

  int n_tests = 0;
  int n_fail  = 0;

  // Register file model: read data is a fixed function of the address.
  function automatic logic [63:0] mem_f(input logic [63:0] a);
    if (a == 64'h4000) return 64'hDEAD_BEEF;
    return {~a[31:0], a[31:0]};
  endfunction

  assign data_i   = mem_f(address_o);
  assign b_data_i = mem_f(b_address);

  reg_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .address_o(address_o), .en_o(en_o), .we_o(we_o), .data_o(data_o), .data_i(data_i)
  );

  reg_port_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(64), .DATA_WIDTH(64)) dut3 (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(b_valid), .req_ready_o(b_ready), .req_addr_i(b_addr),
    .req_we_i(b_we), .req_wdata_i(b_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rdata),
    .address_o(b_address), .en_o(b_en), .we_o(b_wen), .data_o(b_data), .data_i(b_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       mask;   // requesters taking part
    int               n;      // transactions per participating requester
    logic [1:0]       we;
    logic [1:0][63:0] abase;
    logic [1:0][63:0] wbase;
    logic [7:0]       order;  // expected grant sequence, 2 bits per grant, first in [1:0]
  } vec_t;

  typedef struct {
    int          idx;
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } exp_t;

  exp_t expq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [1:0] oh2(input int k);
    logic [1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic [2:0] oh3(input int k);
    logic [2:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  function automatic vec_t mkvec(input logic [1:0] mask, input int n, input logic [1:0] we,
                                 input logic [63:0] a0, input logic [63:0] a1,
                                 input logic [63:0] w0, input logic [63:0] w1,
                                 input logic [7:0] order);
    vec_t v;
    v.mask = mask; v.n = n; v.we = we;
    v.abase[0] = a0; v.abase[1] = a1;
    v.wbase[0] = w0; v.wbase[1] = w1;
    v.order = order;
    return v;
  endfunction

  task automatic drive(input vec_t v, input int k, input int m);
    req_addr_i[k*64 +: 64]  = v.abase[k] + 64'(m * 16);
    req_wdata_i[k*64 +: 64] = v.wbase[k] + 64'(m);
    req_we_i[k]             = v.we[k];
  endtask

  // Apply one table vector: expected transactions go to the scoreboard when stimulus starts,
  // and are popped as the DUT strobes the port and returns responses.
  task automatic run_vec(input vec_t v);
    int   rem[2];
    int   mcnt[2];
    int   mexp[2];
    int   total, done, ready_cyc, gk;
    exp_t e;
    total = 0;
    for (int k = 0; k < 2; k++) begin
      rem[k]  = v.mask[k] ? v.n : 0;
      mcnt[k] = 0;
      mexp[k] = 0;
      total  += rem[k];
    end
    for (int j = 0; j < total; j++) begin
      e.idx   = int'(v.order[2*j +: 2]);
      e.addr  = v.abase[e.idx] + 64'(mexp[e.idx] * 16);
      e.we    = v.we[e.idx];
      e.wdata = v.wbase[e.idx] + 64'(mexp[e.idx]);
      e.rdata = e.we ? 64'h0 : mem_f(e.addr);
      mexp[e.idx]++;
      expq.push_back(e);
    end
    rsp_ready_i = 2'b11;
    done = 0; ready_cyc = -10; gk = -1;
    for (int cyc = 0; cyc < 100 && done < total; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 0) begin
        for (int k = 0; k < 2; k++) begin
          drive(v, k, 0);
          req_valid_i[k] = (rem[k] > 0);
        end
      end
      if (gk >= 0) begin
        rem[gk]--;
        mcnt[gk]++;
        drive(v, gk, mcnt[gk]);
        req_valid_i[gk] = (rem[gk] > 0);
        gk = -1;
      end
      #1;
      if (cyc == ready_cyc + 3 && |req_valid_i)
        chk("throughput_grant", 64'(|req_ready_o), 64'd1);
      if (cyc == ready_cyc + 1) begin
        chk("access_en", 64'(en_o), 64'd1);
        chk("access_we", 64'(we_o), 64'(expq[0].we));
        chk("access_addr", address_o, expq[0].addr);
        chk("access_data", data_o, expq[0].wdata);
      end else begin
        chk("port_idle", 64'(en_o | we_o | (|address_o) | (|data_o)), 64'd0);
      end
      if (cyc == ready_cyc + 2) begin
        chk("rsp_valid", 64'(rsp_valid_o), 64'(oh2(expq[0].idx)));
        chk("rsp_rdata", rsp_rdata_o, expq[0].rdata);
        void'(expq.pop_front());
        done++;
      end else begin
        chk("rsp_idle", 64'(rsp_valid_o) | rsp_rdata_o, 64'd0);
      end
      if (cyc == ready_cyc + 1 || cyc == ready_cyc + 2) begin
        chk("ready_busy", 64'(req_ready_o), 64'd0);
      end else if (|req_ready_o) begin
        if (expq.size() == 0) begin
          chk("extra_grant", 64'(req_ready_o), 64'd0);
        end else begin
          chk("grant", 64'(req_ready_o), 64'(oh2(expq[0].idx)));
          gk = req_ready_o[1] ? 1 : 0;
          ready_cyc = cyc;
        end
      end
    end
    if (done < total) begin
      n_tests++;
      n_fail++;
      $display("FAIL vec_timeout: got %0d responses, expected %0d", done, total);
    end
    expq.delete();
    req_valid_i = 2'b00;
  endtask

  task automatic b_txn(input int k, input logic [63:0] a);
    chk("b_grant", 64'(b_ready), 64'(oh3(k)));
    step();
    b_valid[k] = 1'b0;
    #1;
    chk("b_en", 64'(b_en), 64'd1);
    chk("b_addr", b_address, a);
    step();
    chk("b_rsp_valid", 64'(b_rsp_valid), 64'(oh3(k)));
    chk("b_rsp_rdata", b_rdata, mem_f(a));
  endtask

  vec_t        vecs[5];
  logic [63:0] held;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mkvec(2'b11, 2, 2'b00, 64'h4100, 64'h5000, 64'h0,         64'h0,    8'h44);
    vecs[1] = mkvec(2'b01, 1, 2'b00, 64'h4000, 64'h0,    64'h0,         64'h0,    8'h00);
    vecs[2] = mkvec(2'b10, 1, 2'b10, 64'h0,    64'hBFF8, 64'h0,         64'h1234, 8'h01);
    vecs[3] = mkvec(2'b11, 1, 2'b01, 64'h4300, 64'h5300, 64'hAAAA_0001, 64'h0,    8'h04);
    vecs[4] = mkvec(2'b10, 2, 2'b00, 64'h0,    64'h5400, 64'h0,         64'h0,    8'h05);

    rst_i = 1'b1;
    req_valid_i = '0; req_we_i = '0; req_addr_i = '0; req_wdata_i = '0; rsp_ready_i = 2'b11;
    b_valid = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_rsp_ready = 3'b111;
    repeat (3) step();
    chk("rst_ctrl", 64'({req_ready_o, rsp_valid_o, en_o, we_o}), 64'd0);
    chk("rst_addr", address_o, 64'd0);
    chk("rst_data", data_o, 64'd0);
    chk("rst_rdata", rsp_rdata_o, 64'd0);
    chk("rst_b_ctrl", 64'({b_ready, b_rsp_valid, b_en, b_wen}), 64'd0);
    rst_i = 1'b0;

    // Table: round-robin from reset, single read, write, mixed pair, back-to-back one requester.
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Response backpressure: requester 0 stalls its response while requester 1 waits.
    step();
    req_addr_i[63:0] = 64'h4008; req_addr_i[127:64] = 64'h4010;
    req_we_i = 2'b00; rsp_ready_i = 2'b10; req_valid_i = 2'b11;
    #1;
    chk("bp_grant0", 64'(req_ready_o), 64'(2'b01));
    step();
    req_valid_i[0] = 1'b0;
    #1;
    chk("bp_en", 64'(en_o), 64'd1);
    step();
    held = rsp_rdata_o;
    chk("bp_rsp_valid", 64'(rsp_valid_o), 64'(2'b01));
    chk("bp_rsp_rdata", held, mem_f(64'h4008));
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold_valid", 64'(rsp_valid_o), 64'(2'b01));
      chk("bp_hold_rdata", rsp_rdata_o, held);
      chk("bp_no_ready", 64'(req_ready_o), 64'd0);
      chk("bp_no_en", 64'(en_o), 64'd0);
    end
    rsp_ready_i = 2'b11;
    #1;
    chk("bp_no_ready_hs", 64'(req_ready_o), 64'd0);
    step();
    chk("bp_grant1", 64'(req_ready_o), 64'(2'b10));
    step();
    req_valid_i[1] = 1'b0;
    #1;
    chk("bp_en1_addr", address_o, 64'h4010);
    step();
    chk("bp_rsp1", 64'(rsp_valid_o), 64'(2'b10));

    // Reset while a response is pending: the response is abandoned and ptr_q returns to 0.
    step();
    req_addr_i[63:0] = 64'h4200; req_addr_i[127:64] = 64'h4210;
    req_valid_i = 2'b01;
    #1;
    chk("rr_grant0", 64'(req_ready_o), 64'(2'b01));
    step();
    req_valid_i = 2'b00;
    step();
    chk("rr_rsp_pending", 64'(rsp_valid_o), 64'(2'b01));
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    chk("rr_ctrl_zero", 64'({req_ready_o, rsp_valid_o, en_o, we_o}), 64'd0);
    chk("rr_data_zero", address_o | data_o | rsp_rdata_o, 64'd0);
    req_valid_i = 2'b11;
    #1;
    chk("rr_ptr_reset", 64'(req_ready_o), 64'(2'b01));
    step();
    req_valid_i[0] = 1'b0;
    #1;
    chk("rr_en_addr", address_o, 64'h4200);
    step();
    chk("rr_rsp0", 64'(rsp_valid_o), 64'(2'b01));
    step();
    chk("rr_grant1", 64'(req_ready_o), 64'(2'b10));
    step();
    req_valid_i = 2'b00;
    #1;
    chk("rr_en1_addr", address_o, 64'h4210);
    step();
    chk("rr_rsp1", 64'(rsp_valid_o), 64'(2'b10));

    // Three requesters: move ptr_q to 1, then requesters 0 and 2 compete.
    step();
    b_addr[63:0] = 64'h6000; b_addr[191:128] = 64'h6020;
    b_valid = 3'b001;
    #1;
    b_txn(0, 64'h6000);
    b_valid = 3'b101;
    step();
    b_txn(2, 64'h6020);
    step();
    b_txn(0, 64'h6000);
    step();
    chk("b_idle", 64'({b_ready, b_rsp_valid, b_en}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
